// File: rtl/coco_timer.sv
// coco_timer: memory-mapped countdown timer with CTRL / PRESET / COUNT word
// registers and a maskable interrupt request. One instance serves one bus
// window; the bridge has already decoded the base address and qualified the
// byte strobes, so any nonzero byteen is a legal store to offset addr.
module coco_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // Word offsets inside the window.
  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  // CTRL.MODE encoding; 1x is treated exactly like one-shot.
  localparam logic [1:0] MODE_AUTO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  ctrl;         // [0] EN, [2:1] MODE, [3] IM
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;

  // FSM command strobes, decoded combinationally from the current state.
  logic        load_count;
  logic        dec_count;
  logic        set_pend;
  logic        clr_pend_fsm;
  logic        clr_en;

  // Decoded bus traffic and control fields.
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic        im;
  logic        auto_reload;
  logic [31:0] preset_merged;

  // Replace byte i of old_val with byte i of new_val wherever be[i] is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign wr            = |byteen;
  assign wr_ctrl       = wr && (addr == OFS_CTRL);
  assign wr_preset     = wr && (addr == OFS_PRESET);
  assign en            = ctrl[0];
  assign im            = ctrl[3];
  assign auto_reload   = (ctrl[2:1] == MODE_AUTO);
  assign preset_merged = byte_merge(preset, wdata, byteen);

  // Interrupt output is the pending flag gated by the mask bit, so clearing
  // IM silences irq at once without touching the pending state.
  assign irq = im & irq_pending;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-state commands to the datapath.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    load_count   = 1'b0;
    dec_count    = 1'b0;
    set_pend     = 1'b0;
    clr_pend_fsm = 1'b0;
    clr_en       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_count = 1'b1;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_next = ST_IDLE;           // disabled: COUNT stays frozen
        end else if (count != 32'd0) begin
          dec_count = 1'b1;
        end else begin
          set_pend   = 1'b1;
          state_next = ST_INT;
        end
      end
      ST_INT: begin
        // Auto-reload leaves EN set so IDLE immediately starts the next
        // period; one-shot stops itself and keeps the request latched.
        if (auto_reload) clr_pend_fsm = 1'b1;
        else             clr_en       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // CTRL register: a CPU store to byte 0 overrides the FSM's EN clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= 4'h0;
    end else if (wr_ctrl && byteen[0]) begin
      ctrl <= wdata[3:0];
    end else if (clr_en) begin
      ctrl[0] <= 1'b0;
    end
  end

  // PRESET register: byte-merged stores; only sampled by the FSM in LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         preset <= 32'h0;
    else if (wr_preset) preset <= preset_merged;
  end

  // COUNT register: read-only to the bus, loaded and decremented by the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          count <= 32'h0;
    else if (load_count) count <= preset;
    else if (dec_count)  count <= count - 32'd1;
  end

  // Pending flag: set on expiry; cleared by the INT exit in auto-reload, or
  // by any CTRL/PRESET store in one-shot. A fresh expiry takes precedence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= 1'b0;
    end else if (set_pend) begin
      irq_pending <= 1'b1;
    end else if (clr_pend_fsm) begin
      irq_pending <= 1'b0;
    end else if (!auto_reload && (wr_ctrl || wr_preset)) begin
      irq_pending <= 1'b0;
    end
  end

  // Combinational read mux; unmapped offset and unstored CTRL bits read 0.
  always_comb begin
    rdata = 32'h0;
    case (addr)
      OFS_CTRL:   rdata = {28'h0, ctrl};
      OFS_PRESET: rdata = preset;
      OFS_COUNT:  rdata = count;
      default:    rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_coco_timer.sv
// Self-checking bench for coco_timer. Expected COUNT/irq/CTRL values come
// from closed-form timing rules: with EN written at edge T and PRESET = N,
// COUNT = N at T+2, reaches 0 at T+2+N, irq at T+3+N, auto-reload period N+4.
module tb_coco_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coco_timer dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  // ---------------- reference model (k = edges since the EN-write edge) ----
  function automatic logic [31:0] exp_count(input int k, input int n, input bit auto_m);
    int p;
    if (k < 2) return 32'd0;               // started from reset, COUNT = 0
    p = k - 2;
    if (auto_m) p = p % (n + 4);
    return (p <= n) ? 32'(n - p) : 32'd0;
  endfunction

  function automatic bit exp_pend(input int k, input int n, input bit auto_m);
    if (k < n + 3) return 1'b0;
    if (!auto_m) return 1'b1;
    return ((k - n - 3) % (n + 4)) == 0;
  endfunction

  function automatic bit exp_en(input int k, input int n, input bit auto_m);
    return auto_m ? 1'b1 : (k < n + 4);
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr = a;
    wdata = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    byteen = 4'h0;
    addr = 2'd0;
    wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL reset rdata[%0d]: got %h expected 00000000", a, v);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_oneshot;
    localparam int N = 5;
    logic [31:0] v;
    do_reset();
    bus_write(2'd1, N, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    for (int k = 0; k <= N + 6; k++) begin
      if (k > 0) tick();
      bus_read(2'd2, v);
      checks++;
      if (v !== exp_count(k, N, 1'b0)) begin
        errors++;
        $display("FAIL oneshot count k=%0d: got %0d expected %0d", k, v, exp_count(k, N, 1'b0));
      end
      checks++;
      if (irq !== exp_pend(k, N, 1'b0)) begin
        errors++;
        $display("FAIL oneshot irq k=%0d: got %b expected %b", k, irq, exp_pend(k, N, 1'b0));
      end
    end
    bus_read(2'd0, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("FAIL oneshot ctrl after expiry: got %h expected 8", v);
    end
    bus_write(2'd1, 32'd7, 4'hF);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot irq after preset write: got %b expected 0", irq);
    end
  endtask

  task automatic test_autoreload;
    localparam int N = 2;
    logic [31:0] v;
    int pulses;
    int want;
    pulses = 0;
    want = 0;
    do_reset();
    bus_write(2'd1, N, 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);
    for (int k = 0; k <= 3 * (N + 4) + 3; k++) begin
      if (k > 0) tick();
      bus_read(2'd2, v);
      if (irq === 1'b1) pulses++;
      if (exp_pend(k, N, 1'b1)) want++;
      checks++;
      if (v !== exp_count(k, N, 1'b1) || irq !== exp_pend(k, N, 1'b1)) begin
        errors++;
        $display("FAIL autoreload k=%0d: got count=%0d irq=%b expected count=%0d irq=%b",
                 k, v, irq, exp_count(k, N, 1'b1), exp_pend(k, N, 1'b1));
      end
    end
    checks++;
    if (pulses !== want || want < 3) begin
      errors++;
      $display("FAIL autoreload pulses: got %0d expected %0d", pulses, want);
    end
    bus_read(2'd0, v);
    checks++;
    if (v !== 32'hB) begin
      errors++;
      $display("FAIL autoreload ctrl: got %h expected b", v);
    end
  endtask

  task automatic test_byte_merge;
    logic [31:0] v;
    logic [31:0] model;
    logic [31:0] d;
    logic [3:0]  be;
    do_reset();
    bus_write(2'd1, 32'hFFFF_FFFF, 4'hF);
    bus_write(2'd1, 32'h00AB_0000, 4'b0100);
    bus_read(2'd1, v);
    checks++;
    if (v !== 32'hFFAB_FFFF) begin
      errors++;
      $display("FAIL merge fixed: got %h expected ffabffff", v);
    end
    model = 32'hFFAB_FFFF;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      be = 4'($urandom_range(1, 15));
      bus_write(2'd1, d, be);
      model = model_merge(model, d, be);
      bus_read(2'd1, v);
      checks++;
      if (v !== model) begin
        errors++;
        $display("FAIL merge random be=%b: got %h expected %h", be, v, model);
      end
    end
    // Park COUNT at a nonzero value: load 0x1234, one decrement, then stop.
    bus_write(2'd1, 32'h1234, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);
    tick();
    tick();
    bus_write(2'd0, 32'h0, 4'hF);
    bus_write(2'd2, 32'hDEAD_BEEF, 4'hF);
    tick();
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'h1233) begin
      errors++;
      $display("FAIL count write ignored: got %h expected 00001233", v);
    end
    bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL offset3 read: got %h expected 00000000", v);
    end
    bus_write(2'd0, 32'hFFFF_FFF6, 4'hF);
    bus_read(2'd0, v);
    checks++;
    if (v !== 32'h6) begin
      errors++;
      $display("FAIL ctrl upper bits: got %h expected 00000006", v);
    end
  endtask

  task automatic test_disable;
    logic [31:0] v;
    bit found;
    found = 1'b0;
    do_reset();
    bus_write(2'd1, 32'd100, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    for (int i = 0; i < 40 && !found; i++) begin
      bus_read(2'd2, v);
      if (v == 32'd90) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL disable wait: got count %0d expected 90 within 40 cycles", v);
    end
    bus_write(2'd0, 32'h8, 4'hF);      // lands one edge after COUNT = 90
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd2, v);
      checks++;
      if (v !== 32'd89 || irq !== 1'b0) begin
        errors++;
        $display("FAIL disable frozen i=%0d: got count=%0d irq=%b expected count=89 irq=0", i, v, irq);
      end
      tick();
    end
    bus_write(2'd0, 32'h9, 4'hF);
    tick();
    tick();
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'd100) begin
      errors++;
      $display("FAIL disable reload: got %0d expected 100", v);
    end
  endtask

  task automatic test_preset_zero;
    do_reset();
    bus_write(2'd1, 32'd0, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (irq !== (k >= 3)) begin
        errors++;
        $display("FAIL preset0 irq k=%0d: got %b expected %b", k, irq, (k >= 3));
      end
    end
  endtask

  task automatic test_restart_on_int;
    localparam int N = 3;
    logic [31:0] v;
    do_reset();
    bus_write(2'd1, N, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    repeat (N + 3) tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL restart irq at INT: got %b expected 1", irq);
    end
    bus_write(2'd0, 32'h9, 4'hF);      // same edge as INT -> IDLE
    bus_read(2'd0, v);
    checks++;
    if (v !== 32'h9 || irq !== 1'b0) begin
      errors++;
      $display("FAIL restart ctrl/irq: got ctrl=%h irq=%b expected ctrl=9 irq=0", v, irq);
    end
    tick();
    tick();
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'(N)) begin
      errors++;
      $display("FAIL restart reload: got %0d expected %0d", v, N);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] c;
    logic [31:0] v;
    do_reset();
    bus_write(2'd1, 32'd50, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    repeat (5) tick();
    bus_read(2'd2, v);
    checks++;
    if (v !== 32'd47) begin
      errors++;
      $display("FAIL async pre count: got %0d expected 47", v);
    end
    reset = 1'b0;                       // mid-cycle, no clock edge follows yet
    #1;
    bus_read(2'd0, c);
    bus_read(2'd2, v);
    checks++;
    if (c !== 32'h0 || v !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async mid-count: got ctrl=%h count=%h irq=%b expected all 0", c, v, irq);
    end
    do_reset();
    bus_write(2'd1, 32'd1, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    repeat (4) tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL async pre irq: got %b expected 1", irq);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL async irq: got %b expected 0", irq);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] v;
    int n;
    int mode;
    bit im;
    bit auto_m;
    int last;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 8);
      mode = $urandom_range(0, 3);
      im = 1'($urandom_range(0, 1));
      auto_m = (mode == 1);
      last = 2 * (n + 4) + 4;
      do_reset();
      bus_write(2'd1, n, 4'hF);
      bus_write(2'd0, {28'h0, im, 2'(mode), 1'b1}, 4'hF);
      for (int k = 0; k <= last; k++) begin
        if (k > 0) tick();
        bus_read(2'd2, v);
        checks++;
        if (v !== exp_count(k, n, auto_m) || irq !== (im & exp_pend(k, n, auto_m))) begin
          errors++;
          $display("FAIL random n=%0d mode=%0d im=%b k=%0d: got count=%0d irq=%b expected count=%0d irq=%b",
                   n, mode, im, k, v, irq, exp_count(k, n, auto_m), im & exp_pend(k, n, auto_m));
        end
      end
      bus_read(2'd0, v);
      checks++;
      if (v !== {28'h0, im, 2'(mode), exp_en(last, n, auto_m)}) begin
        errors++;
        $display("FAIL random ctrl n=%0d mode=%0d: got %h expected %h", n, mode, v,
                 {28'h0, im, 2'(mode), exp_en(last, n, auto_m)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_byte_merge();
    test_disable();
    test_preset_zero();
    test_restart_on_int();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
